pc_fetch_ctrl: RTL and testbench

Program counter and fetch sequencer for the single-cycle core. It owns the instruction address register: it starts a program on a start pulse and steps sequentially. On a taken branch it jumps to the absolute target produced by the branch-target lookup table. It stops on halt and reports completion plus a run-cycle count to the test harness.

---
 rtl/pc_fetch_ctrl.sv | 115 +++++++++++
 tb/tb_pc_fetch_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter and fetch sequencer for the single-cycle core.
// Owns the instruction address register. A start pulse launches a program,
// the PC then steps sequentially or jumps to an absolute branch target, and
// halt parks the sequencer with a completion flag and a run-cycle count.
module pc_fetch_ctrl #(
    parameter int             D          = 10,
    parameter logic [D-1:0]   START_ADDR = '0,
    parameter int             CW         = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          halt,
    input  logic          stall,
    input  logic          branch,
    input  logic [D-1:0]  target,
    output logic [D-1:0]  pc,
    output logic          running,
    output logic          done,
    output logic [CW-1:0] cycles,
    output logic          wrap_err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [D-1:0]  PC_MAX  = {D{1'b1}};
    localparam logic [CW-1:0] CYC_MAX = {CW{1'b1}};

    logic [1:0]    state_q, state_d;
    logic [D-1:0]  pc_q, pc_d;
    logic [CW-1:0] cycles_q, cycles_d;
    logic          wrap_q, wrap_d;

    // Next-state and next-PC selection; halt outranks stall, stall outranks branch.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        pc_d     = pc_q;
        cycles_d = cycles_q;
        wrap_d   = wrap_q;

        case (state_q)
            ST_IDLE: begin
                pc_d = START_ADDR;
                if (start) begin
                    state_d  = ST_RUN;
                    cycles_d = '0;
                    wrap_d   = 1'b0;
                end
            end

            ST_RUN: begin
                // Every RUN cycle counts, stalled and halting ones included.
                if (cycles_q != CYC_MAX) begin
                    cycles_d = cycles_q + CW'(1);
                end

                if (halt) begin
                    // PC stays on the halt instruction.
                    state_d = ST_HALTED;
                end else if (!stall) begin
                    if (branch) begin
                        // Target 0 is a legal jump, not an error.
                        pc_d = target;
                    end else begin
                        pc_d = pc_q + D'(1);
                        if (pc_q == PC_MAX) begin
                            wrap_d = 1'b1;
                        end
                    end
                end
                // A stalled cycle drops any branch presented with it.
            end

            ST_HALTED: begin
                if (start) begin
                    state_d  = ST_RUN;
                    pc_d     = START_ADDR;
                    cycles_d = '0;
                    wrap_d   = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                pc_d    = START_ADDR;
            end
        endcase
    end

    // State registers with synchronous active-low reset that overrides all inputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= START_ADDR;
            cycles_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cycles_q <= cycles_d;
            wrap_q   <= wrap_d;
        end
    end

    assign pc       = pc_q;
    assign running  = (state_q == ST_RUN);
    assign done     = (state_q == ST_HALTED);
    assign cycles   = cycles_q;
    assign wrap_err = wrap_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed testbench for pc_fetch_ctrl. Three instances: the default
// configuration, a 4-bit PC for wrap behaviour, and a 3-bit counter with a
// non-zero start address for saturation.
module tb_pc_fetch_ctrl;

    logic clk;
    int   checks = 0;
    int   errors = 0;

    // Main instance: D=10, CW=16, START_ADDR=0
    logic        rst_n, start, halt, stall, branch;
    logic [9:0]  target;
    logic [9:0]  pc;
    logic        running, done, wrap_err;
    logic [15:0] cycles;

    // Wrap instance: D=4
    logic        rst_n_w, start_w, halt_w, stall_w, branch_w;
    logic [3:0]  target_w;
    logic [3:0]  pc_w;
    logic        running_w, done_w, wrap_err_w;
    logic [15:0] cycles_w;

    // Saturation instance: CW=3, START_ADDR=5
    logic        rst_n_s, start_s, halt_s, stall_s, branch_s;
    logic [9:0]  target_s;
    logic [9:0]  pc_s;
    logic        running_s, done_s, wrap_err_s;
    logic [2:0]  cycles_s;

    pc_fetch_ctrl #(.D(10), .START_ADDR(10'd0), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .stall(stall),
        .branch(branch), .target(target), .pc(pc), .running(running),
        .done(done), .cycles(cycles), .wrap_err(wrap_err)
    );

    pc_fetch_ctrl #(.D(4), .START_ADDR(4'd0), .CW(16)) dut_w (
        .clk(clk), .rst_n(rst_n_w), .start(start_w), .halt(halt_w), .stall(stall_w),
        .branch(branch_w), .target(target_w), .pc(pc_w), .running(running_w),
        .done(done_w), .cycles(cycles_w), .wrap_err(wrap_err_w)
    );

    pc_fetch_ctrl #(.D(10), .START_ADDR(10'd5), .CW(3)) dut_s (
        .clk(clk), .rst_n(rst_n_s), .start(start_s), .halt(halt_s), .stall(stall_s),
        .branch(branch_s), .target(target_s), .pc(pc_s), .running(running_s),
        .done(done_s), .cycles(cycles_s), .wrap_err(wrap_err_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; halt = 1'b0; stall = 1'b0; branch = 1'b0; target = '0;
        rst_n_w = 1'b0; start_w = 1'b0; halt_w = 1'b0; stall_w = 1'b0; branch_w = 1'b0; target_w = '0;
        rst_n_s = 1'b0; start_s = 1'b0; halt_s = 1'b0; stall_s = 1'b0; branch_s = 1'b0; target_s = '0;

        // Reset with noisy inputs: reset must win
        start = 1'b1; branch = 1'b1; target = 10'd33;
        step();
        check("rst_pc", pc, 0);
        check("rst_running", running, 0);
        check("rst_done", done, 0);
        check("rst_cycles", cycles, 0);
        check("rst_wrap", wrap_err, 0);
        check("rst_pc_s", pc_s, 5);

        // IDLE ignores branch/halt
        rst_n = 1'b1; start = 1'b0; halt = 1'b1;
        step();
        check("idle_pc", pc, 0);
        check("idle_running", running, 0);
        check("idle_done", done, 0);

        // Start: first fetch address is START_ADDR
        halt = 1'b0; branch = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        check("start_running", running, 1);
        check("start_pc", pc, 0);
        check("start_cycles", cycles, 0);

        // 5 free-running cycles: pc 1..5
        for (int i = 1; i <= 5; i++) begin
            step();
            check("seq_pc", pc, i);
        end
        check("seq_cycles", cycles, 5);
        check("seq_running", running, 1);
        check("seq_done", done, 0);

        // Advance to pc=7 (start held high in RUN is ignored)
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        check("pc7", pc, 7);

        // Branch to 2, then sequential 3, 4
        branch = 1'b1; target = 10'd2;
        step();
        branch = 1'b0;
        check("br_pc", pc, 2);
        step();
        check("br_pc3", pc, 3);
        step();
        check("br_pc4", pc, 4);
        check("br_wrap", wrap_err, 0);
        check("br_cycles", cycles, 10);

        // Stall 3 cycles at pc=4, then stall+branch (branch dropped)
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", pc, 4);
        end
        branch = 1'b1; target = 10'd20;
        step();
        check("stall_br_pc", pc, 4);
        check("stall_cycles", cycles, 14);
        stall = 1'b0; branch = 1'b0;
        step();
        check("post_stall_pc", pc, 5);
        check("post_stall_cycles", cycles, 15);

        // Advance to pc=9, then halt together with branch
        for (int i = 0; i < 4; i++) step();
        check("pc9", pc, 9);
        halt = 1'b1; branch = 1'b1; target = 10'd100;
        step();
        halt = 1'b0; branch = 1'b0;
        check("halt_done", done, 1);
        check("halt_running", running, 0);
        check("halt_pc", pc, 9);
        check("halt_cycles", cycles, 20);

        // HALTED holds everything for 10 cycles despite noise
        stall = 1'b1; branch = 1'b1; target = 10'd50;
        for (int i = 0; i < 10; i++) step();
        stall = 1'b0; branch = 1'b0;
        check("hold_pc", pc, 9);
        check("hold_cycles", cycles, 20);
        check("hold_done", done, 1);

        // Restart from HALTED
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_pc", pc, 0);
        check("restart_cycles", cycles, 0);
        check("restart_running", running, 1);
        check("restart_done", done, 0);

        // Branch to 0 (legal) and branch-to-self loop
        step();
        check("rs_pc1", pc, 1);
        branch = 1'b1; target = 10'd0;
        step();
        check("br0_pc", pc, 0);
        check("br0_wrap", wrap_err, 0);
        step();
        branch = 1'b0;
        check("self_pc", pc, 0);

        // Run to pc=12, then reset mid-RUN with start asserted
        for (int i = 0; i < 12; i++) step();
        check("pc12", pc, 12);
        rst_n = 1'b0; start = 1'b1;
        step();
        check("midrst_pc", pc, 0);
        check("midrst_running", running, 0);
        check("midrst_cycles", cycles, 0);
        check("midrst_wrap", wrap_err, 0);
        rst_n = 1'b1;
        step();
        start = 1'b0;
        check("resume_running", running, 1);
        check("resume_pc", pc, 0);
        step();
        check("resume_pc1", pc, 1);
        check("resume_cycles", cycles, 1);

        // D=4 wrap: run to 15, one more cycle wraps to 0 and sets wrap_err
        rst_n_w = 1'b1; start_w = 1'b1;
        step();
        start_w = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check("w_pc15", pc_w, 15);
        check("w_nowrap", wrap_err_w, 0);
        step();
        check("w_pc0", pc_w, 0);
        check("w_wrap", wrap_err_w, 1);
        branch_w = 1'b1; target_w = 4'd3;
        step();
        branch_w = 1'b0;
        check("w_br_pc", pc_w, 3);
        check("w_wrap_sticky", wrap_err_w, 1);
        halt_w = 1'b1;
        step();
        halt_w = 1'b0;
        check("w_halt_done", done_w, 1);
        check("w_halt_wrap", wrap_err_w, 1);
        start_w = 1'b1;
        step();
        start_w = 1'b0;
        check("w_restart_wrap", wrap_err_w, 0);
        check("w_restart_pc", pc_w, 0);
        check("w_restart_cycles", cycles_w, 0);

        // CW=3 saturation with START_ADDR=5
        rst_n_s = 1'b1; start_s = 1'b1;
        step();
        start_s = 1'b0;
        check("s_start_pc", pc_s, 5);
        for (int i = 0; i < 10; i++) step();
        check("s_cycles_sat", cycles_s, 7);
        check("s_pc", pc_s, 15);
        check("s_running", running_s, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
